// File: rtl/ddr_resp_pkg.sv
// Shared types for the DDR4 device-side responder: command/error codes, burst type,
// command pin decode and backing-store index helpers.
package ddr_resp_pkg;

    localparam int DQ_W_DEF   = 8;
    localparam int BURST_W    = 8 * DQ_W_DEF;
    localparam int ROW_W      = 18;
    localparam int IDX_FULL_W = ROW_W + 2 + 2 + 7;

    typedef logic [BURST_W-1:0] burst_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_RD,
        CMD_WR,
        CMD_REF,
        CMD_MRS
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ACT_OPEN    = 3'd1,
        ERR_BANK_CLOSED = 3'd2,
        ERR_TCCD_VIOL   = 3'd3,
        ERR_REF_OPEN    = 3'd4
    } err_e;

    function automatic cmd_e decode_cmd(input logic cs_n, input logic act_n,
                                        input logic ras_n, input logic cas_n,
                                        input logic we_n);
        cmd_e c;
        c = CMD_NOP;
        if (!cs_n) begin
            if (!act_n) begin
                c = CMD_ACT;
            end else begin
                case ({ras_n, cas_n, we_n})
                    3'b010:  c = CMD_PRE;
                    3'b101:  c = CMD_RD;
                    3'b100:  c = CMD_WR;
                    3'b001:  c = CMD_REF;
                    3'b000:  c = CMD_MRS;
                    default: c = CMD_NOP;
                endcase
            end
        end
        return c;
    endfunction

    // Full-width store index; the top keeps only its low address bits.
    function automatic logic [IDX_FULL_W-1:0] full_index(input logic [ROW_W-1:0] row,
                                                         input logic [1:0] bg,
                                                         input logic [1:0] ba,
                                                         input logic [6:0] col_hi);
        return {row, bg, ba, col_hi};
    endfunction

endpackage

// File: rtl/ddr_resp_delay_line.sv
// Valid + payload shift register used to schedule read and write bursts a fixed
// number of cycles after their command; cleared by reset so nothing survives it.
module ddr_resp_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock_t,
    input  logic         reset_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ddr_cmd_responder.sv
// DDR4 device-side responder: decodes commands, tracks open rows, captures write bursts
// after WL, returns read bursts after RL from a small store, and flags protocol errors.
module ddr_cmd_responder
    import ddr_resp_pkg::*;
#(
    parameter int CL       = 13,
    parameter int CWL      = 10,
    parameter int AL       = 0,
    parameter int TCCD     = 4,
    parameter int DQ_W     = 8,
    parameter int STORE_AW = 10
) (
    input  logic              clock_t,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              act_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [1:0]        bg,
    input  logic [1:0]        ba,
    input  logic [17:0]       addr,
    input  logic [2*DQ_W-1:0] dq_wr_data,
    output logic [2*DQ_W-1:0] dq_rd_data,
    output logic              dq_rd_valid,
    output logic              dqs_rd_en,
    output logic [15:0]       bank_open,
    output logic              proto_err,
    output logic [2:0]        err_code
);

    localparam int RL     = AL + CL;
    localparam int WL     = AL + CWL;
    localparam int PW     = 2 * DQ_W;
    localparam int BW     = 8 * DQ_W;
    localparam int NENT   = 1 << STORE_AW;
    localparam int CCD_W  = $clog2(TCCD + 1);

    cmd_e                  cmd;
    err_e                  err_d;
    logic [3:0]            bank;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [IDX_FULL_W-1:0] idx_full;
    logic [STORE_AW-1:0]   cmd_idx;

    logic [ROW_W-1:0]      row_q [16];
    logic [15:0]           open_q;
    logic [CCD_W-1:0]      ccd_q;
    logic                  proto_err_q;
    logic [2:0]            err_code_q;

    logic                  rd_fire;
    logic [STORE_AW-1:0]   rd_idx;
    logic                  wr_fire;
    logic [STORE_AW-1:0]   wr_fire_idx;

    logic [BW-1:0]         store_mem [NENT];
    logic [NENT-1:0]       written_q;

    logic [BW-1:0]         wr_asm_q;
    logic [STORE_AW-1:0]   wr_idx_q;
    logic [1:0]            wr_beat_q;
    logic                  wr_act_q;
    logic                  wr_commit_q;

    logic [BW-1:0]         rd_burst_q;
    logic [1:0]            rd_beat_q;
    logic                  rd_act_q;
    logic [PW-1:0]         dq_rd_data_q;
    logic                  dq_rd_valid_q;
    logic                  dqs_rd_en_q;

    assign bank     = {bg, ba};
    assign idx_full = full_index(row_q[bank], bg, ba, addr[9:3]);
    assign cmd_idx  = idx_full[STORE_AW-1:0];

    // Legality check; a rejected RD/WR never enters a pipeline or restarts tCCD.
    always_comb begin
        cmd    = decode_cmd(cs_n, act_n, ras_n, cas_n, we_n);
        err_d  = ERR_NONE;
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        case (cmd)
            CMD_ACT: begin
                if (open_q[bank]) err_d = ERR_ACT_OPEN;
            end
            CMD_RD, CMD_WR: begin
                if (!open_q[bank]) begin
                    err_d = ERR_BANK_CLOSED;
                end else if (ccd_q != '0) begin
                    err_d = ERR_TCCD_VIOL;
                end else begin
                    rd_acc = (cmd == CMD_RD);
                    wr_acc = (cmd == CMD_WR);
                end
            end
            CMD_REF: begin
                if (|open_q) err_d = ERR_REF_OPEN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            open_q      <= '0;
            ccd_q       <= '0;
            proto_err_q <= 1'b0;
            err_code_q  <= 3'd0;
            for (int i = 0; i < 16; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            proto_err_q <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) err_code_q <= err_d;

            if (rd_acc || wr_acc) begin
                ccd_q <= CCD_W'(TCCD - 1);
            end else if (ccd_q != '0) begin
                ccd_q <= ccd_q - CCD_W'(1);
            end

            if (cmd == CMD_ACT && err_d == ERR_NONE) begin
                open_q[bank] <= 1'b1;
                row_q[bank]  <= addr;
            end else if (cmd == CMD_PRE) begin
                if (addr[10]) open_q       <= '0;
                else          open_q[bank] <= 1'b0;
            end else if ((rd_acc || wr_acc) && addr[10]) begin
                open_q[bank] <= 1'b0;
            end
        end
    end

    // Read schedule ends one cycle early so the store lookup lands at RL-1.
    ddr_resp_delay_line #(.DEPTH(RL - 1), .W(STORE_AW)) u_rd_dly (
        .clock_t     (clock_t),
        .reset_n     (reset_n),
        .in_valid_i  (rd_acc),
        .in_data_i   (cmd_idx),
        .out_valid_o (rd_fire),
        .out_data_o  (rd_idx)
    );

    ddr_resp_delay_line #(.DEPTH(WL), .W(STORE_AW)) u_wr_dly (
        .clock_t     (clock_t),
        .reset_n     (reset_n),
        .in_valid_i  (wr_acc),
        .in_data_i   (cmd_idx),
        .out_valid_o (wr_fire),
        .out_data_o  (wr_fire_idx)
    );

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            wr_asm_q    <= '0;
            wr_idx_q    <= '0;
            wr_beat_q   <= 2'd0;
            wr_act_q    <= 1'b0;
            wr_commit_q <= 1'b0;
            written_q   <= '0;
        end else begin
            wr_commit_q <= wr_act_q && (wr_beat_q == 2'd3);
            if (wr_commit_q) written_q[wr_idx_q] <= 1'b1;

            if (wr_fire) begin
                wr_asm_q[PW-1:0] <= dq_wr_data;
                wr_idx_q         <= wr_fire_idx;
                wr_beat_q        <= 2'd1;
                wr_act_q         <= 1'b1;
            end else if (wr_act_q) begin
                wr_asm_q[int'(wr_beat_q)*PW +: PW] <= dq_wr_data;
                wr_beat_q <= wr_beat_q + 2'd1;
                if (wr_beat_q == 2'd3) wr_act_q <= 1'b0;
            end
        end
    end

    // Store contents survive reset; only the written bitmap is cleared.
    always_ff @(posedge clock_t) begin
        if (wr_commit_q) store_mem[wr_idx_q] <= wr_asm_q;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            rd_burst_q    <= '0;
            rd_beat_q     <= 2'd0;
            rd_act_q      <= 1'b0;
            dq_rd_data_q  <= '0;
            dq_rd_valid_q <= 1'b0;
            dqs_rd_en_q   <= 1'b0;
        end else begin
            dqs_rd_en_q   <= rd_fire | rd_act_q;
            dq_rd_valid_q <= rd_act_q;
            dq_rd_data_q  <= rd_act_q ? rd_burst_q[int'(rd_beat_q)*PW +: PW] : '0;

            if (rd_act_q) begin
                rd_beat_q <= rd_beat_q + 2'd1;
                if (rd_beat_q == 2'd3) rd_act_q <= 1'b0;
            end
            // A back-to-back burst reloads here while the last beat of the previous one is output.
            if (rd_fire) begin
                rd_burst_q <= written_q[rd_idx] ? store_mem[rd_idx] : '0;
                rd_beat_q  <= 2'd0;
                rd_act_q   <= 1'b1;
            end
        end
    end

    assign dq_rd_data  = dq_rd_data_q;
    assign dq_rd_valid = dq_rd_valid_q;
    assign dqs_rd_en   = dqs_rd_en_q;
    assign bank_open   = open_q;
    assign proto_err   = proto_err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ddr_cmd_responder.sv
// Scoreboard bench for ddr_cmd_responder: a per-command reference model predicts read
// bursts, strobe windows, errors and bank state; a negedge monitor compares.
module tb_ddr_cmd_responder;
    import ddr_resp_pkg::*;

    localparam int RL   = 13;
    localparam int WL   = 10;
    localparam int TCCD = 4;
    localparam int MAXC = 6000;

    typedef enum int {K_NOP, K_DES, K_ACT, K_PRE, K_RD, K_WR, K_REF, K_MRS} kind_e;
    typedef struct { int cyc; logic [15:0] data; } rx_t;
    typedef struct { int cyc; int idx; burst_t data; } pw_t;

    logic        clock_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1, act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  bg = 2'd0, ba = 2'd0;
    logic [17:0] addr = 18'd0;
    logic [15:0] dq_wr_data = 16'd0;
    logic [15:0] dq_rd_data;
    logic        dq_rd_valid, dqs_rd_en, proto_err;
    logic [15:0] bank_open;
    logic [2:0]  err_code;

    ddr_cmd_responder dut (
        .clock_t(clock_t), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba), .addr(addr),
        .dq_wr_data(dq_wr_data), .dq_rd_data(dq_rd_data), .dq_rd_valid(dq_rd_valid),
        .dqs_rd_en(dqs_rd_en), .bank_open(bank_open), .proto_err(proto_err),
        .err_code(err_code)
    );

    always #5 clock_t = ~clock_t;

    int cyc = 0;
    always @(posedge clock_t) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] wdata     [MAXC];
    bit          dqs_exp   [MAXC];
    bit          err_exp   [MAXC];
    logic [2:0]  code_hist [MAXC];
    logic [15:0] bank_hist [MAXC];

    bit          m_open [16];
    int          m_row  [16];
    int          last_cc;
    logic [2:0]  last_code;
    burst_t      mem [int];
    pw_t         pend [$];
    rx_t         rq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        last_cc   = -100;
        last_code = 3'd0;
        mem.delete();
        pend.delete();
        rq.delete();
    endtask

    task automatic model(input int T, input kind_e k, input int b, input int row,
                         input int col, input bit a10);
        int     err;
        int     idx;
        int     i;
        burst_t d;
        err = 0;
        case (k)
            K_ACT: begin
                if (m_open[b]) err = 1;
                else begin
                    m_open[b] = 1'b1;
                    m_row[b]  = row;
                end
            end
            K_PRE: begin
                if (a10) for (int j = 0; j < 16; j++) m_open[j] = 1'b0;
                else m_open[b] = 1'b0;
            end
            K_RD, K_WR: begin
                if (!m_open[b]) err = 2;
                else if (T - last_cc < TCCD) err = 3;
                else begin
                    last_cc = T;
                    idx = ((m_row[b] << 11) | (b << 7) | ((col >> 3) & 127)) & 1023;
                    if (k == K_RD) begin
                        i = 0;
                        while (i < pend.size()) begin
                            if (pend[i].cyc < T + RL - 1) begin
                                mem[pend[i].idx] = pend[i].data;
                                pend.delete(i);
                            end else begin
                                i++;
                            end
                        end
                        d = mem.exists(idx) ? mem[idx] : '0;
                        for (int j = 0; j < 4; j++) rq.push_back('{T + RL + j, d[16*j +: 16]});
                        for (int j = 0; j < 5; j++) dqs_exp[T + RL - 1 + j] = 1'b1;
                    end else begin
                        for (int j = 0; j < 4; j++) d[16*j +: 16] = wdata[T + WL + j];
                        pend.push_back('{T + WL + 4, idx, d});
                    end
                    if (a10) m_open[b] = 1'b0;
                end
            end
            K_REF: begin
                for (int j = 0; j < 16; j++) if (m_open[j]) err = 4;
            end
            default: ;
        endcase
        if (err != 0) begin
            err_exp[T] = 1'b1;
            last_code  = 3'(err);
        end
        code_hist[T] = last_code;
        for (int j = 0; j < 16; j++) bank_hist[T][j] = m_open[j];
    endtask

    task automatic step(input kind_e k, input int b, input int row, input int col, input bit a10);
        int T;
        int r;
        T          = cyc + 1;
        cs_n       = 1'b0;
        act_n      = 1'b1;
        bg         = 2'(b >> 2);
        ba         = 2'(b & 3);
        addr       = 18'($urandom);
        dq_wr_data = wdata[T];
        case (k)
            K_NOP: begin
                r = $urandom_range(0, 2);
                {ras_n, cas_n, we_n} = (r == 0) ? 3'b111 : (r == 1) ? 3'b110 : 3'b011;
            end
            K_DES: begin
                cs_n  = 1'b1;
                act_n = 1'($urandom);
                {ras_n, cas_n, we_n} = 3'($urandom);
            end
            K_ACT: begin
                act_n = 1'b0;
                {ras_n, cas_n, we_n} = 3'($urandom);
                addr = 18'(row);
            end
            K_PRE: begin {ras_n, cas_n, we_n} = 3'b010; addr[10] = a10; end
            K_RD:  begin {ras_n, cas_n, we_n} = 3'b101; addr[10] = a10; addr[9:0] = 10'(col); end
            K_WR:  begin {ras_n, cas_n, we_n} = 3'b100; addr[10] = a10; addr[9:0] = 10'(col); end
            K_REF: {ras_n, cas_n, we_n} = 3'b001;
            default: {ras_n, cas_n, we_n} = 3'b000;
        endcase
        model(T, k, b, row, col, a10);
        @(posedge clock_t);
        #1;
    endtask

    task automatic nop(input int n);
        repeat (n) step(K_NOP, 0, 0, 0, 1'b0);
    endtask

    task automatic wr_pattern(input int b, input int col);
        int T;
        T = cyc + 1;
        for (int j = 0; j < 4; j++) wdata[T + WL + j] = {8'(2*j + 1), 8'(2*j)};
        step(K_WR, b, 0, col, 1'b0);
    endtask

    task automatic do_reset(input int k);
        int n;
        n = cyc;
        reset_n = 1'b0;
        cs_n    = 1'b1;
        model_clear();
        for (int c = n; c < n + 40; c++) begin
            dqs_exp[c] = 1'b0;
            err_exp[c] = 1'b0;
        end
        for (int c = n; c <= n + k; c++) begin
            code_hist[c] = 3'd0;
            bank_hist[c] = 16'd0;
        end
        repeat (k) begin
            @(posedge clock_t);
            #1;
        end
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        rx_t e;
        int  m;
        @(posedge clock_t);
        forever begin
            @(negedge clock_t);
            m = cyc;
            chk("dqs_rd_en", 32'(dqs_rd_en), 32'(dqs_exp[m]));
            chk("proto_err", 32'(proto_err), 32'(err_exp[m]));
            chk("err_code", 32'(err_code), 32'(code_hist[m]));
            chk("bank_open", 32'(bank_open), 32'(bank_hist[m]));
            if (!reset_n) begin
                chk("rd_valid_in_reset", 32'(dq_rd_valid), 32'd0);
                chk("rd_data_in_reset", 32'(dq_rd_data), 32'd0);
            end
            if (dq_rd_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(dq_rd_valid), 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_beat_cycle", 32'(m), 32'(e.cyc));
                    chk("rd_beat_data", 32'(dq_rd_data), 32'(e.data));
                end
            end else if (rq.size() > 0 && rq[0].cyc <= m) begin
                e = rq.pop_front();
                chk("missing_rd_valid", 32'(dq_rd_valid), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cycle %0d actual running required finished", cyc);
        $fatal(1, "time limit");
    end

    initial begin : driver
        kind_e k;
        int    p, b, row, col;
        bit    a10;
        for (int c = 0; c < MAXC; c++) begin
            wdata[c]     = 16'($urandom);
            code_hist[c] = 3'd0;
            bank_hist[c] = 16'd0;
        end
        model_clear();
        repeat (5) @(posedge clock_t);
        #1;
        reset_n = 1'b1;

        step(K_ACT, 0, 5, 0, 1'b0); nop(2);
        wr_pattern(0, 0);           nop(20);
        step(K_RD, 0, 0, 0, 1'b0);  nop(20);
        step(K_RD, 0, 0, 8, 1'b0);  nop(20);
        step(K_ACT, 0, 7, 0, 1'b0); nop(2);
        step(K_RD, 5, 0, 0, 1'b0);  nop(2);
        step(K_REF, 0, 0, 0, 1'b0); nop(2);
        step(K_RD, 0, 0, 0, 1'b0);  nop(1);
        step(K_RD, 0, 0, 0, 1'b0);  nop(20);
        step(K_RD, 0, 0, 0, 1'b0);  nop(3);
        step(K_RD, 0, 0, 8, 1'b0);  nop(20);
        step(K_RD, 0, 0, 0, 1'b1);  nop(4);
        step(K_RD, 0, 0, 0, 1'b0);  nop(4);
        step(K_ACT, 1, 2, 0, 1'b0); nop(2);
        step(K_WR, 1, 0, 16, 1'b0); nop(WL + 1);
        do_reset(3);
        step(K_ACT, 1, 2, 0, 1'b0); nop(2);
        step(K_RD, 1, 0, 16, 1'b0); nop(20);

        for (int s = 0; s < 2000; s++) begin
            p   = $urandom_range(0, 99);
            b   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            row = $urandom_range(0, 3);
            col = $urandom_range(0, 31);
            a10 = ($urandom_range(0, 6) == 0);
            if      (p < 30) k = K_NOP;
            else if (p < 34) k = K_DES;
            else if (p < 49) k = K_ACT;
            else if (p < 57) k = K_PRE;
            else if (p < 77) k = K_RD;
            else if (p < 95) k = K_WR;
            else if (p < 97) k = K_REF;
            else             k = K_MRS;
            step(k, b, row, col, a10);
        end
        step(K_PRE, 0, 0, 0, 1'b1);
        nop(30);

        chk("reads_outstanding", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
